// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: checks size/alignment, issues word-aligned accesses,
// extracts and extends load data. Optional perf counters under macro LSU_PERF_CNT_EN.
module mem_access_ctrl #(
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [2:0]  mem_size,
    output logic        mem_en,
    output logic        mem_wr,
    input  logic [31:0] mem_data_out,
    input  logic        mem_exception,
    output logic [15:0] perf_loads,
    output logic [15:0] perf_stores,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_ACCESS = 2'd2;
    localparam logic [1:0] FAULT_SIZE = 2'd3;

    state_t      state_q, state_d;
    logic        wr_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [1:0]  fault_q;

    logic        illegal_size;
    logic        misaligned;
    logic [31:0] repl_wdata;
    logic [31:0] load_data;

    // Stores only exist in B/H/W form; the unsigned encodings are load-only.
    assign illegal_size = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                          (req_wr && req_funct3[2]);
    assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        repl_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00:   repl_wdata = {4{req_wdata[7:0]}};
            2'b01:   repl_wdata = {2{req_wdata[15:0]}};
            default: repl_wdata = req_wdata;
        endcase
    end

    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b    = 8'h00;
        lane_h    = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
        load_data = mem_data_out;
        case (addr_q[1:0])
            2'b00:   lane_b = mem_data_out[7:0];
            2'b01:   lane_b = mem_data_out[15:8];
            2'b10:   lane_b = mem_data_out[23:16];
            default: lane_b = mem_data_out[31:24];
        endcase
        case (funct3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'h0, lane_b};
            3'b101:  load_data = {16'h0, lane_h};
            default: load_data = mem_data_out;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (illegal_size || misaligned) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_en  = 1'b1;
                mem_wr  = wr_q;
                state_d = wr_q ? RESP : WAIT;
            end
            WAIT: begin
                // Enable stays high: the downstream read mux is gated by it.
                mem_en = 1'b1;
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= 2'd0;
            rdata_q  <= 32'h0;
            fault_q  <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q     <= req_wr;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= repl_wdata;
                        cnt_q    <= CNT_INIT;
                        rdata_q  <= 32'h0;
                        fault_q  <= illegal_size ? FAULT_SIZE :
                                    misaligned   ? FAULT_MISALIGN : FAULT_NONE;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        fault_q <= mem_exception ? FAULT_ACCESS : FAULT_NONE;
                    end
                end
                WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        fault_q <= mem_exception ? FAULT_ACCESS : FAULT_NONE;
                        rdata_q <= mem_exception ? 32'h0 : load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_data_in = wdata_q;
    assign mem_size    = funct3_q;
    assign rsp_rdata   = (state_q == RESP) ? rdata_q : 32'h0;
    assign rsp_fault   = (state_q == RESP) ? fault_q : FAULT_NONE;
    assign dbg_state   = state_q;

`ifdef LSU_PERF_CNT_EN
    logic [15:0] loads_q;
    logic [15:0] stores_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            loads_q  <= 16'h0;
            stores_q <= 16'h0;
        end else if ((state_q == RESP) && (fault_q == FAULT_NONE)) begin
            if (wr_q) begin
                stores_q <= stores_q + 16'd1;
            end else begin
                loads_q <= loads_q + 16'd1;
            end
        end
    end

    assign perf_loads  = loads_q;
    assign perf_stores = stores_q;
`else
    assign perf_loads  = 16'h0;
    assign perf_stores = 16'h0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized bench for mem_access_ctrl with an expected-response queue.
module tb_mem_access_ctrl;

    localparam int RL = 2;

    logic        CLK;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [2:0]  mem_size;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_data_out;
    logic        mem_exception;
    logic [15:0] perf_loads;
    logic [15:0] perf_stores;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];
    int          lat_q[$];
    int          model_loads = 0;
    int          model_stores = 0;

    mem_access_ctrl #(.READ_LATENCY(RL)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_size(mem_size),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
        .mem_exception(mem_exception), .perf_loads(perf_loads),
        .perf_stores(perf_stores), .dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference extraction: shift the addressed lane down, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // One request; watches the access and response for up to 20 cycles.
    task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdword, input logic exc,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_fault,
                           input int exp_lat, input int exp_en,
                           input logic [31:0] exp_mdi, input bit hold);
        int  en_cyc;
        int  wr_cyc;
        bit  seen;
        logic [33:0] e;
        int  el;
        en_cyc = 0;
        wr_cyc = 0;
        seen = 0;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge CLK);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_wr = wr;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        mem_data_out = rdword;
        mem_exception = exc;
        exp_q.push_back({exp_fault, exp_rdata});
        lat_q.push_back(exp_lat);
        @(posedge CLK);
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge CLK);
            if (n == 1 && !hold) req_valid = 1'b0;
            if (mem_en) begin
                en_cyc++;
                chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({tag, "_mem_size"}, {29'h0, mem_size}, {29'h0, f3});
                if (wr) chk({tag, "_mem_data_in"}, mem_data_in, exp_mdi);
            end
            if (mem_wr) wr_cyc++;
            if (rsp_valid) begin
                seen = 1;
                e = exp_q.pop_front();
                el = lat_q.pop_front();
                chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
                chk({tag, "_fault"}, {30'h0, rsp_fault}, {30'h0, e[33:32]});
                chk({tag, "_latency"}, n, el);
            end
        end
        if (!seen) begin
            chk({tag, "_rsp_timeout"}, 32'h0, 32'h1);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        chk({tag, "_en_cycles"}, en_cyc, exp_en);
        chk({tag, "_wr_cycles"}, wr_cyc, (wr && exp_en > 0) ? 1 : 0);
        if (exp_fault == 2'd0) begin
            if (wr) model_stores++;
            else model_loads++;
        end
        if (hold) begin
            @(negedge CLK);
            req_valid = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge CLK);
                chk({tag, "_no_requeue"}, {31'h0, rsp_valid | mem_en}, 32'h0);
            end
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef LSU_PERF_CNT_EN
        chk({tag, "_perf_loads"}, {16'h0, perf_loads}, 32'(model_loads & 16'hFFFF));
        chk({tag, "_perf_stores"}, {16'h0, perf_stores}, 32'(model_stores & 16'hFFFF));
`else
        chk({tag, "_perf_loads"}, {16'h0, perf_loads}, 32'h0);
        chk({tag, "_perf_stores"}, {16'h0, perf_stores}, 32'h0);
`endif
    endtask

    initial begin
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] w;
        logic [2:0]  sizes [4];
        sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b100; sizes[3] = 3'b101;
        reset = 1'b0;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        mem_data_out = 32'h0;
        mem_exception = 1'b0;
        #12;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_outs", {29'h0, rsp_valid, mem_en, mem_wr}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        chk("rst_rsp", rsp_rdata | {30'h0, rsp_fault} | {29'h0, mem_size}, 32'h0);
        check_perf("rst");
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);

        run_req("sw", 1, 3'b010, 32'h0100_0004, 32'hDEAD_BEEF, 32'h0, 0,
                32'h0, 2'd0, 2, 1, 32'hDEAD_BEEF, 0);
        run_req("lb", 0, 3'b000, 32'h0100_0007, 32'h0, 32'h80FF_1234, 0,
                32'hFFFF_FF80, 2'd0, 2 + RL, 1 + RL, 32'h0, 0);
        run_req("lbu", 0, 3'b100, 32'h0100_0007, 32'h0, 32'h80FF_1234, 0,
                32'h0000_0080, 2'd0, 2 + RL, 1 + RL, 32'h0, 0);
        run_req("sh", 1, 3'b001, 32'h0100_0002, 32'h0000_A55A, 32'h0, 0,
                32'h0, 2'd0, 2, 1, 32'hA55A_A55A, 0);
        run_req("sb", 1, 3'b000, 32'h0200_0003, 32'h1234_56C3, 32'h0, 0,
                32'h0, 2'd0, 2, 1, 32'hC3C3_C3C3, 0);
        run_req("lw_mis", 0, 3'b010, 32'h0000_0002, 32'h0, 32'h0, 0,
                32'h0, 2'd1, 1, 0, 32'h0, 0);
        run_req("lh_mis", 0, 3'b001, 32'h0100_0001, 32'h0, 32'hFFFF_FFFF, 0,
                32'h0, 2'd1, 1, 0, 32'h0, 0);
        run_req("st_size", 1, 3'b100, 32'h0100_0000, 32'h1, 32'h0, 0,
                32'h0, 2'd3, 1, 0, 32'h0, 0);
        run_req("ld_011", 0, 3'b011, 32'h0100_0000, 32'h0, 32'h0, 0,
                32'h0, 2'd3, 1, 0, 32'h0, 0);
        run_req("ld_110", 0, 3'b110, 32'h0100_0000, 32'h0, 32'h0, 0,
                32'h0, 2'd3, 1, 0, 32'h0, 0);
        run_req("lw_exc", 0, 3'b010, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1,
                32'h0, 2'd2, 2 + RL, 1 + RL, 32'h0, 0);
        run_req("sw_exc", 1, 3'b010, 32'h0000_0020, 32'h1111_2222, 32'h0, 1,
                32'h0, 2'd2, 2, 1, 32'h1111_2222, 0);
        run_req("lh", 0, 3'b001, 32'h0100_0002, 32'h0, 32'h8001_7FFF, 0,
                32'hFFFF_8001, 2'd0, 2 + RL, 1 + RL, 32'h0, 0);
        run_req("lhu", 0, 3'b101, 32'h0100_0000, 32'h0, 32'h8001_8FFF, 0,
                32'h0000_8FFF, 2'd0, 2 + RL, 1 + RL, 32'h0, 0);
        run_req("lw_hold", 0, 3'b010, 32'h0100_0008, 32'h0, 32'h1234_5678, 0,
                32'h1234_5678, 2'd0, 2 + RL, 1 + RL, 32'h0, 1);

        for (int i = 0; i < 6; i++) begin
            f3 = sizes[$urandom_range(0, 3)];
            off = 2'($urandom_range(0, 3));
            if (f3[0]) off[0] = 1'b0;
            w = $urandom;
            run_req("rnd_ld", 0, f3, {8'h01, 22'($urandom), off}, 32'h0, w, 0,
                    model_load(f3, off, w), 2'd0, 2 + RL, 1 + RL, 32'h0, 0);
        end
        @(negedge CLK);
        check_perf("mid");

        // Reset during WAIT abandons the load.
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h0100_0040;
        mem_exception = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_mid_in_wait", {30'h0, dbg_state}, 32'd2);
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        model_loads = 0;
        model_stores = 0;
        check_perf("rst_mid");
        @(negedge CLK);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("rst_mid_no_rsp", {31'h0, rsp_valid | mem_en}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
